ryuki_if_trace_ctrl: RTL

- Sequences timestamp capture for the Ryuki instruction-fetch stage and assembles one trace_output record per fetched instruction.
- Watches the core's instruction-memory handshake (req/gnt/rvalid) and the IF-stage completion strobe.
- Stamps each phase against a free-running cycle counter and queues finished records in a small FIFO.
- Sits between the core's IF interface and the trace sink, which drains the FIFO with valid/ready.

---
 rtl/ryuki_datatypes.sv | 22 ++
 rtl/ryuki_trace_fifo.sv | 35 +++
 rtl/ryuki_if_trace_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/ryuki_datatypes.sv
// ryuki_datatypes: trace record types and IF trace FSM states shared by the IF trace controller
package ryuki_datatypes;
  localparam int TIME_W = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DROP_CNT_WIDTH = 16;
  typedef struct packed {
    logic [TIME_W-1:0] time_start;
    logic [TIME_W-1:0] time_end;
  } mem_access;
  typedef struct packed {
    logic [TIME_W-1:0] time_start;
    logic [TIME_W-1:0] time_end;
    mem_access         mem_acc;
  } IF_data;
  typedef struct packed {
    logic [DATA_W-1:0] instruction;
    logic [ADDR_W-1:0] addr;
    IF_data            if_data;
  } trace_output;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_IF} if_trace_state_e;
endpackage

// File: rtl/ryuki_trace_fifo.sv
// ryuki_trace_fifo: first-word fall-through FIFO of trace records, extra pointer bit for full/empty
module ryuki_trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  trace_output push_data,
  input  logic        pop,
  output trace_output pop_data,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  trace_output mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/ryuki_if_trace_ctrl.sv
// ryuki_if_trace_ctrl: timestamps IF fetch phases and queues one trace record per instruction.
// RYUKI_TRACE_DROP_CNT_EN enables the saturating dropped-record counter on drop_cnt_o.
module ryuki_if_trace_ctrl
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIME_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_req_i,
  input  logic                      instr_gnt_i,
  input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
  input  logic                      instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     instr_rdata_i,
  input  logic                      if_valid_i,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output trace_output               trace_o,
  output logic                      dropped_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
  if_trace_state_e state;
  logic [TIME_WIDTH-1:0] cnt, t_start, t_mem_end;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic req_take, gnt_take, rv_take, push, pop, full, empty;
  trace_output rec;
  // Phases may collapse into one cycle, so each event also fires from earlier states
  assign req_take = state == IDLE && instr_req_i;
  assign gnt_take = instr_gnt_i && (req_take || state == WAIT_GNT);
  assign rv_take = instr_rvalid_i && (gnt_take || state == WAIT_RVALID);
  assign push = if_valid_i && (rv_take || state == WAIT_IF);
  assign pop = trace_valid_o && trace_ready_i;
  assign trace_valid_o = !empty;
  assign dropped_o = push && full && !pop;
  always_comb begin
    rec.instruction = rv_take ? instr_rdata_i : rdata_q;
    rec.addr = gnt_take ? instr_addr_i : addr_q;
    rec.if_data.time_start = req_take ? cnt : t_start;
    rec.if_data.time_end = cnt;
    rec.if_data.mem_acc.time_start = req_take ? cnt : t_start;
    rec.if_data.mem_acc.time_end = rv_take ? cnt : t_mem_end;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      t_start <= '0;
      t_mem_end <= '0;
      addr_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      t_start <= rec.if_data.time_start;
      t_mem_end <= rec.if_data.mem_acc.time_end;
      addr_q <= rec.addr;
      rdata_q <= rec.instruction;
      state <= push ? IDLE : rv_take ? WAIT_IF : gnt_take ? WAIT_RVALID : req_take ? WAIT_GNT : state;
    end
  ryuki_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(rec),
    .pop      (pop),
    .pop_data (trace_o),
    .full     (full),
    .empty    (empty)
  );
`ifdef RYUKI_TRACE_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (dropped_o && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif
endmodule
